// File: rtl/hpc_pkg.sv
// Shared addresses, register-bank bit positions and state encoding for the
// measurement master.
package hpc_pkg;

    localparam logic [3:0] A_ADDR = 4'h0;
    localparam logic [3:0] B_ADDR = 4'h4;
    localparam logic [3:0] O_ADDR = 4'h8;

    localparam int ENABLE_BIT = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_A,
        S_WR_B,
        S_RUN,
        S_RD,
        S_RD_WAIT,
        S_DIS,
        S_DONE
    } hpc_state_t;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic [3:0] addr;
    } cmd_hdr_t;

endpackage

// File: rtl/hpc_bus_cmd.sv
// Single-transfer Avalon-MM issue/hold unit: registers one command onto the bus.
// Latency: strobes appear the cycle after issue_vld; xfer_done marks the completing cycle.
// Backpressure: with HPC_MASTER_WAITREQ_EN the command is held until waitrequest is low.
module hpc_bus_cmd
    import hpc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_vld,
    input  cmd_hdr_t         issue_hdr,
    input  logic [WIDTH-1:0] issue_dat,
`ifdef HPC_MASTER_WAITREQ_EN
    input  logic             master_waitrequest,
`endif
    output logic             xfer_done,
    output logic [3:0]       master_address,
    output logic             master_read,
    output logic             master_write,
    output logic [WIDTH-1:0] master_writedata
);

    logic held;

    assign held = master_read | master_write;

`ifdef HPC_MASTER_WAITREQ_EN
    assign xfer_done = held & ~master_waitrequest;
`else
    assign xfer_done = held;
`endif

    // A new command may be loaded in the same cycle the previous one completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            master_address   <= '0;
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_writedata <= '0;
        end else if (issue_vld) begin
            master_address   <= issue_hdr.addr;
            master_read      <= issue_hdr.rd;
            master_write     <= issue_hdr.wr;
            master_writedata <= issue_dat;
        end else if (xfer_done) begin
            master_address   <= '0;
            master_read      <= 1'b0;
            master_write     <= 1'b0;
            master_writedata <= '0;
        end
    end

endmodule

// File: rtl/hpc_master.sv
// Avalon-MM master running one measurement: write ctrl/seed, idle N cycles, read count, disable.
// Latency: done in cycle N+5+RD_LATENCY after start (plus stalls); busy covers cycles 1..done.
// Backpressure: HPC_MASTER_WAITREQ_EN adds master_waitrequest, stretching each transfer; start ignored while busy.
module hpc_master
    import hpc_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CNT_W      = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] i_cfg_a,
    input  logic [WIDTH-1:0] i_cfg_b,
    input  logic [CNT_W-1:0] i_run_cycles,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] o_result,
    output logic [3:0]       master_address,
    output logic             master_read,
    output logic             master_write,
    output logic [WIDTH-1:0] master_writedata,
`ifdef HPC_MASTER_WAITREQ_EN
    input  logic             master_waitrequest,
`endif
    input  logic [WIDTH-1:0] master_readdata
);

    localparam int               LAT_W   = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [WIDTH-1:0] EN_MASK = WIDTH'(1) << ENABLE_BIT;

    hpc_state_t       state;
    logic [WIDTH-1:0] cfg_a_q;
    logic [WIDTH-1:0] cfg_b_q;
    logic [CNT_W-1:0] run_q;
    logic [CNT_W-1:0] run_cnt;
    logic [LAT_W-1:0] lat_cnt;

    logic             issue_vld;
    cmd_hdr_t         issue_hdr;
    logic [WIDTH-1:0] issue_dat;
    logic             xfer_done;

    // Next bus command, loaded into the issue unit on the edge that enters the bus state.
    always_comb begin
        issue_vld = 1'b0;
        issue_hdr = '0;
        issue_dat = '0;
        case (state)
            S_IDLE: if (start) begin
                issue_vld = 1'b1;
                issue_hdr = '{rd: 1'b0, wr: 1'b1, addr: A_ADDR};
                issue_dat = i_cfg_a | EN_MASK;
            end
            S_WR_A: if (xfer_done) begin
                issue_vld = 1'b1;
                issue_hdr = '{rd: 1'b0, wr: 1'b1, addr: B_ADDR};
                issue_dat = cfg_b_q;
            end
            S_WR_B: if (xfer_done && run_q == '0) begin
                issue_vld = 1'b1;
                issue_hdr = '{rd: 1'b1, wr: 1'b0, addr: O_ADDR};
            end
            S_RUN: if (run_cnt == CNT_W'(1)) begin
                issue_vld = 1'b1;
                issue_hdr = '{rd: 1'b1, wr: 1'b0, addr: O_ADDR};
            end
            S_RD_WAIT: if (lat_cnt == '0) begin
                issue_vld = 1'b1;
                issue_hdr = '{rd: 1'b0, wr: 1'b1, addr: A_ADDR};
                issue_dat = cfg_a_q & ~EN_MASK;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cfg_a_q  <= '0;
            cfg_b_q  <= '0;
            run_q    <= '0;
            run_cnt  <= '0;
            lat_cnt  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            o_result <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    cfg_a_q <= i_cfg_a;
                    cfg_b_q <= i_cfg_b;
                    run_q   <= i_run_cycles;
                    busy    <= 1'b1;
                    state   <= S_WR_A;
                end
                S_WR_A: if (xfer_done) state <= S_WR_B;
                S_WR_B: if (xfer_done) begin
                    if (run_q == '0) begin
                        state <= S_RD;
                    end else begin
                        run_cnt <= run_q;
                        state   <= S_RUN;
                    end
                end
                // Down-counter ends at 1 so a full-scale count never wraps.
                S_RUN: begin
                    if (run_cnt == CNT_W'(1)) state <= S_RD;
                    else                      run_cnt <= run_cnt - CNT_W'(1);
                end
                S_RD: if (xfer_done) begin
                    lat_cnt <= LAT_W'(RD_LATENCY - 1);
                    state   <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        o_result <= master_readdata;
                        state    <= S_DIS;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                S_DIS: if (xfer_done) begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    hpc_bus_cmd #(.WIDTH(WIDTH)) u_bus (
        .clk                (clk),
        .reset              (reset),
        .issue_vld          (issue_vld),
        .issue_hdr          (issue_hdr),
        .issue_dat          (issue_dat),
`ifdef HPC_MASTER_WAITREQ_EN
        .master_waitrequest (master_waitrequest),
`endif
        .xfer_done          (xfer_done),
        .master_address     (master_address),
        .master_read        (master_read),
        .master_write       (master_write),
        .master_writedata   (master_writedata)
    );

endmodule

// File: tb/tb_hpc_master.sv
// Scoreboard bench for hpc_master: timeline model of each run vs. bus, busy, done and result.
// A second instance with RD_LATENCY=3 checks late read-data capture.
module tb_hpc_master;

    localparam int LAT = 1;
`ifdef HPC_MASTER_WAITREQ_EN
    localparam int W = 2;
`else
    localparam int W = 0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, start3;
    logic [31:0] cfg_a, cfg_b;
    logic [15:0] run_cycles;

    logic        busy, done, m_rd, m_wr;
    logic [31:0] o_result, m_wdat, m_rdat;
    logic [3:0]  m_addr;
    logic        busy3, done3, m3_rd, m3_wr;
    logic [31:0] o_result3, m3_wdat, m3_rdat;
    logic [3:0]  m3_addr;
`ifdef HPC_MASTER_WAITREQ_EN
    logic        waitreq = 1'b0;
`endif

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        int          cyc;
    } bus_t;

    bus_t        exp_q[$];
    logic [31:0] res_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          ecnt    = 0;
    int          s_edge  = 0;
    int          d_edge  = 0;
    int          n_cur   = 0;
    bit          win_valid = 0;
    int          s3 = 0;
    int          n3 = 0;
    bit          valid3 = 0;
    logic [31:0] slave_val = '0;
    logic [31:0] pend_val  = '0;
    int          rd_cd = 0;
    int          rd3_cd = 0;
    int          stall = 0;

    hpc_master #(.WIDTH(32), .CNT_W(16), .RD_LATENCY(LAT)) u_dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .i_cfg_a            (cfg_a),
        .i_cfg_b            (cfg_b),
        .i_run_cycles       (run_cycles),
        .busy               (busy),
        .done               (done),
        .o_result           (o_result),
        .master_address     (m_addr),
        .master_read        (m_rd),
        .master_write       (m_wr),
        .master_writedata   (m_wdat),
`ifdef HPC_MASTER_WAITREQ_EN
        .master_waitrequest (waitreq),
`endif
        .master_readdata    (m_rdat)
    );

    hpc_master #(.WIDTH(32), .CNT_W(16), .RD_LATENCY(3)) u_dut3 (
        .clk                (clk),
        .reset              (reset),
        .start              (start3),
        .i_cfg_a            (cfg_a),
        .i_cfg_b            (cfg_b),
        .i_run_cycles       (run_cycles),
        .busy               (busy3),
        .done               (done3),
        .o_result           (o_result3),
        .master_address     (m3_addr),
        .master_read        (m3_rd),
        .master_write       (m3_wr),
        .master_writedata   (m3_wdat),
`ifdef HPC_MASTER_WAITREQ_EN
        .master_waitrequest (1'b0),
`endif
        .master_readdata    (m3_rdat)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    // Slave models: read data valid for exactly one cycle, LAT (or 3) cycles after the accepted read.
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            rd_cd   = 0;
            rd3_cd  = 0;
            stall   = 0;
            m_rdat  = '0;
            m3_rdat = '0;
`ifdef HPC_MASTER_WAITREQ_EN
            waitreq = 1'b0;
`endif
        end else begin
            if (rd_cd > 0) begin
                rd_cd--;
                m_rdat = (rd_cd == 0) ? pend_val : 32'($urandom);
            end else begin
                m_rdat = 32'($urandom);
            end
            if (rd3_cd > 0) begin
                rd3_cd--;
                m3_rdat = (rd3_cd == 0) ? 32'h55 : 32'h0;
            end else begin
                m3_rdat = 32'h0;
            end
`ifdef HPC_MASTER_WAITREQ_EN
            waitreq = (m_rd | m_wr) && (m_addr == 4'h4 || m_addr == 4'h8) && stall < 2;
            if ((m_rd | m_wr) && waitreq) stall++;
            else                          stall = 0;
            if (m_rd && !waitreq) begin
                rd_cd    = LAT;
                pend_val = slave_val;
            end
`else
            if (m_rd) begin
                rd_cd    = LAT;
                pend_val = slave_val;
            end
`endif
            if (m3_rd) rd3_cd = 3;
        end
    end

    // Monitor: compares every cycle's bus, busy, done and result against the queued expectations.
    always @(negedge clk) begin
        bus_t e;
        logic acc;
`ifdef HPC_MASTER_WAITREQ_EN
        acc = (m_rd | m_wr) && !waitreq;
`else
        acc = m_rd | m_wr;
`endif
        chk("one_strobe", 32'(m_rd & m_wr), 32'h0);
        if (m_rd | m_wr) begin
            if (exp_q.size() == 0) begin
                chk("bus_unexpected", {30'h0, m_wr, m_rd}, 32'h0);
            end else begin
                e = exp_q[0];
                chk("bus_kind", 32'(m_wr), 32'(e.wr));
                chk("bus_addr", 32'(m_addr), 32'(e.addr));
                if (e.wr) chk("bus_wdata", m_wdat, e.data);
                if (acc) begin
                    chk("bus_cycle", ecnt, e.cyc);
                    void'(exp_q.pop_front());
                end
            end
        end else begin
            chk("idle_addr", 32'(m_addr), 32'h0);
            chk("idle_wdata", m_wdat, 32'h0);
        end
        chk("busy", 32'(busy), 32'(win_valid && ecnt >= s_edge && ecnt <= d_edge));
        chk("done", 32'(done), 32'(win_valid && ecnt == d_edge));
        if (done) begin
            if (res_q.size() == 0) chk("result_unexpected", 32'(done), 32'h0);
            else                   chk("o_result", o_result, res_q.pop_front());
        end
        chk("done3", 32'(done3), 32'(valid3 && ecnt == s3 + n3 + 7));
        if (done3) chk("o_result3", o_result3, 32'h55);
    end

    task automatic start_run(input logic [31:0] a, input logic [31:0] b, input int n,
                             input logic [31:0] rv, input bit use3);
        @(negedge clk);
        #1;
        cfg_a      = a;
        cfg_b      = b;
        run_cycles = 16'(n);
        start      = 1'b1;
        start3     = use3;
        s_edge     = ecnt + 1;
        n_cur      = n;
        d_edge     = s_edge + n + 4 + LAT + 2 * W;
        win_valid  = 1'b1;
        slave_val  = rv;
        exp_q.push_back('{1'b1, 4'h0, a | 32'h1,  s_edge});
        exp_q.push_back('{1'b1, 4'h4, b,          s_edge + 1 + W});
        exp_q.push_back('{1'b0, 4'h8, 32'h0,      s_edge + n + 2 + 2 * W});
        exp_q.push_back('{1'b1, 4'h0, a & ~32'h1, s_edge + n + 3 + LAT + 2 * W});
        res_q.push_back(rv);
        if (use3) begin
            s3     = s_edge;
            n3     = n;
            valid3 = 1'b1;
        end
        @(negedge clk);
        #1;
        start      = 1'b0;
        start3     = 1'b0;
        cfg_a      = $urandom;
        cfg_b      = $urandom;
        run_cycles = 16'($urandom_range(0, 50));
    endtask

    task automatic wait_cycle(input int c);
        while (ecnt < s_edge + c - 1) @(negedge clk);
    endtask

    task automatic finish_run(input bit b2b);
        int dd;
        dd = d_edge - s_edge + 1;
        if (b2b) begin
            wait_cycle(dd);
        end else begin
            wait_cycle((dd > n_cur + 8) ? dd : n_cur + 8);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    initial begin
        bit b2b;
        bit prev_b2b;
        reset = 1'b1; start = 1'b0; start3 = 1'b0;
        cfg_a = '0; cfg_b = '0; run_cycles = '0;
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_result", o_result, 32'h0);
        chk("rst_strobes", {30'h0, m_wr, m_rd}, 32'h0);
        chk("rst_addr", 32'(m_addr), 32'h0);
        chk("rst_busy3", 32'(busy3), 32'h0);
        @(negedge clk);
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);

        start_run(32'h0, 32'h1234, 5, 32'hABCD, 1'b1);
        finish_run(1'b0);
        chk("basic_result", o_result, 32'hABCD);

        start_run($urandom, $urandom, 0, $urandom, 1'b1);
        finish_run(1'b0);

        start_run(32'h0000_00F1, 32'h0BAD_0002, 8, 32'hCAFE_0001, 1'b1);
        wait_cycle(4);
        #1;
        start = 1'b1; start3 = 1'b1; cfg_a = 32'hFFFF_FFFF; run_cycles = 16'd2;
        @(negedge clk);
        #1;
        start = 1'b0; start3 = 1'b0;
        finish_run(1'b0);

        start_run($urandom, $urandom, 10, $urandom, 1'b1);
        wait_cycle(5);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_strobes", {30'h0, m_wr, m_rd}, 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        chk("mid_rst_result", o_result, 32'h0);
        chk("mid_rst_result3", o_result3, 32'h0);
        exp_q.delete();
        res_q.delete();
        win_valid = 1'b0;
        valid3    = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        start_run($urandom, $urandom, 3, $urandom, 1'b1);
        finish_run(1'b0);

        prev_b2b = 1'b0;
        for (int i = 0; i < 12; i++) begin
            b2b = (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
            start_run($urandom, $urandom, $urandom_range(0, 12), $urandom, !prev_b2b);
            finish_run(b2b);
            prev_b2b = b2b;
        end

        repeat (4) @(negedge clk);
        chk("bus_queue_drained", 32'(exp_q.size()), 32'h0);
        chk("result_queue_drained", 32'(res_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
